exe_sequencer: RTL

- Issue/retire controller in front of the EXE stage (Mux2 + ALU + Branch_Unit).
- Accepts one decoded operation per valid/ready handshake and holds its operands stable on the EXE inputs for the op's latency, which is parameter-set per alu_op.
- Captures alu_result, branch_taken and jaddr_out and presents them downstream with a valid/ready handshake.
- Raises a one-cycle flush when a taken branch retires; multi-cycle modular ops (alu_op 2'b11) stall the front end.

---
 rtl/exe_pkg.sv | 33 +++
 rtl/exe_sequencer_if.sv | 59 +++++
 rtl/exe_lat_counter.sv | 25 ++
 rtl/exe_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared types and helpers for the EXE-stage issue/retire sequencer.
package exe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] ALU_OP_MUL = 2'b11;

    localparam int unsigned EXE_ARQ = 16;
    localparam int unsigned EXE_RW  = 4;

    typedef struct packed {
        logic [1:0]         alu_op;
        logic               mux_exe;
        logic               jop_lsb;
        logic [EXE_ARQ-1:0] src1;
        logic [EXE_ARQ-1:0] src2;
        logic [EXE_ARQ-1:0] srcdest;
        logic [EXE_ARQ-1:0] imm;
        logic [12:0]        jaddr;
        logic [EXE_RW-1:0]  rd;
    } exe_op_t;

    function automatic int unsigned lat_of(input logic [1:0]  op,
                                           input int unsigned alu_lat,
                                           input int unsigned mul_lat);
        return (op == ALU_OP_MUL) ? mul_lat : alu_lat;
    endfunction

endpackage

// File: rtl/exe_sequencer_if.sv
// Upstream op, EXE datapath and downstream result signals of the sequencer.
interface exe_sequencer_if #(
    parameter int unsigned ARQ = 16,
    parameter int unsigned RW  = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_alu_op;
    logic           in_mux_exe;
    logic           in_jop_lsb;
    logic [ARQ-1:0] in_src1;
    logic [ARQ-1:0] in_src2;
    logic [ARQ-1:0] in_srcdest;
    logic [ARQ-1:0] in_imm;
    logic [12:0]    in_jaddr;
    logic [RW-1:0]  in_rd;

    logic [1:0]     exe_alu_op;
    logic           exe_mux_exe;
    logic           exe_jop_lsb;
    logic [ARQ-1:0] exe_src1;
    logic [ARQ-1:0] exe_src2;
    logic [ARQ-1:0] exe_srcdest;
    logic [ARQ-1:0] exe_imm;
    logic [12:0]    exe_jaddr;
    logic [ARQ-1:0] alu_result;
    logic           branch_taken;
    logic [12:0]    jaddr_out;

    logic           out_valid;
    logic           out_ready;
    logic [ARQ-1:0] out_result;
    logic [RW-1:0]  out_rd;
    logic           flush;
    logic [12:0]    flush_addr;
    logic           busy;

    modport slave (
        input  in_valid, in_alu_op, in_mux_exe, in_jop_lsb, in_src1, in_src2,
               in_srcdest, in_imm, in_jaddr, in_rd,
        output in_ready,
        output exe_alu_op, exe_mux_exe, exe_jop_lsb, exe_src1, exe_src2,
               exe_srcdest, exe_imm, exe_jaddr,
        input  alu_result, branch_taken, jaddr_out,
        output out_valid, out_result, out_rd, flush, flush_addr, busy,
        input  out_ready
    );

    modport master (
        output in_valid, in_alu_op, in_mux_exe, in_jop_lsb, in_src1, in_src2,
               in_srcdest, in_imm, in_jaddr, in_rd,
        input  in_ready,
        input  exe_alu_op, exe_mux_exe, exe_jop_lsb, exe_src1, exe_src2,
               exe_srcdest, exe_imm, exe_jaddr,
        output alu_result, branch_taken, jaddr_out,
        input  out_valid, out_result, out_rd, flush, flush_addr, busy,
        output out_ready
    );
endinterface

// File: rtl/exe_lat_counter.sv
// Loadable down-counter timing the EXE latency; flags when it reaches zero.
module exe_lat_counter #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] val_i,
    input  logic          en_i,
    output logic          zero_o
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/exe_sequencer.sv
// Issue/retire controller: holds one op on the EXE inputs for its latency,
// captures the result and retires it downstream, flushing on taken branches.
module exe_sequencer
    import exe_pkg::*;
#(
    parameter int unsigned ARQ     = 16,
    parameter int unsigned RW      = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 4
) (
    input logic            clk,
    input logic            rst,
    input logic            kill,
    exe_sequencer_if.slave bus
);
    localparam int unsigned MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT) + 1;

    seq_state_t     state_q;
    logic [1:0]     alu_op_q;
    logic           mux_exe_q;
    logic           jop_lsb_q;
    logic [ARQ-1:0] src1_q;
    logic [ARQ-1:0] src2_q;
    logic [ARQ-1:0] srcdest_q;
    logic [ARQ-1:0] imm_q;
    logic [12:0]    jaddr_q;
    logic [RW-1:0]  rd_q;
    logic [ARQ-1:0] out_result_q;
    logic [RW-1:0]  out_rd_q;
    logic           taken_q;
    logic [12:0]    addr_q;

    logic           in_ready_d;
    logic           accept;
    logic           cnt_zero;
    logic [CW-1:0]  cnt_d;

    // A retiring taken branch blocks acceptance so the redirect wins.
    always_comb begin
        in_ready_d = 1'b0;
        if (!kill) begin
            case (state_q)
                IDLE:    in_ready_d = 1'b1;
                DONE:    in_ready_d = bus.out_ready & ~taken_q;
                default: in_ready_d = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid & in_ready_d;
    assign cnt_d  = CW'(lat_of(bus.in_alu_op, ALU_LAT, MUL_LAT) - 1);

    exe_lat_counter #(
        .CW (CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .val_i  (cnt_d),
        .en_i   (state_q == EXEC),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            alu_op_q     <= '0;
            mux_exe_q    <= 1'b0;
            jop_lsb_q    <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            srcdest_q    <= '0;
            imm_q        <= '0;
            jaddr_q      <= '0;
            rd_q         <= '0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            taken_q      <= 1'b0;
            addr_q       <= '0;
        end else if (kill) begin
            state_q <= IDLE;
            taken_q <= 1'b0;
        end else if (accept) begin
            alu_op_q  <= bus.in_alu_op;
            mux_exe_q <= bus.in_mux_exe;
            jop_lsb_q <= bus.in_jop_lsb;
            src1_q    <= bus.in_src1;
            src2_q    <= bus.in_src2;
            srcdest_q <= bus.in_srcdest;
            imm_q     <= bus.in_imm;
            jaddr_q   <= bus.in_jaddr;
            rd_q      <= bus.in_rd;
            state_q   <= EXEC;
        end else begin
            case (state_q)
                EXEC: begin
                    if (cnt_zero) begin
                        out_result_q <= bus.alu_result;
                        out_rd_q     <= rd_q;
                        taken_q      <= bus.branch_taken;
                        addr_q       <= bus.jaddr_out;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        taken_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_d;
    assign bus.exe_alu_op  = alu_op_q;
    assign bus.exe_mux_exe = mux_exe_q;
    assign bus.exe_jop_lsb = jop_lsb_q;
    assign bus.exe_src1    = src1_q;
    assign bus.exe_src2    = src2_q;
    assign bus.exe_srcdest = srcdest_q;
    assign bus.exe_imm     = imm_q;
    assign bus.exe_jaddr   = jaddr_q;
    assign bus.out_valid   = (state_q == DONE) & ~kill;
    assign bus.out_result  = out_result_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.flush       = (state_q == DONE) & taken_q & bus.out_ready & ~kill;
    assign bus.flush_addr  = addr_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
